pciecfg_mgmt_responder: RTL
===========================

// Module: pciecfg_mgmt_responder
// PURPOSE
//  Responder end of the PCIe cfg_mgmt configuration interface: services dword
//  read/write requests from a cfg_mgmt initiator (pciecfg_core) against a local
//  configuration-space register file, returning cfg_mgmt_do/cfg_mgmt_rd_wr_done.
//  Used in place of the hard PCIe block in simulation and in loopback emulation builds.
// PARAMETERS
//  NUM_DW        64            implemented dwords (1..1024); dwaddr >= NUM_DW unimplemented
//  RESP_LATENCY  4             cycles from request accept to done pulse (1..15)
//  ID_DW0        32'h7021_10EE read-only value of dword 0 (device/vendor ID)
//  CLASS_DW2     32'h0580_0000 read-only value of dword 2 (class code/revision)
// PORTS
//  clk                  in   1   clock
//  rst_n                in   1   reset, asynchronous, active-low
//  cfg_mgmt_dwaddr      in   10  dword address
//  cfg_mgmt_rd_en       in   1   read request, held high by initiator until done
//  cfg_mgmt_wr_en       in   1   write request, held high by initiator until done
//  cfg_mgmt_byte_en     in   4   write byte enables, bit i -> di[8i+7:8i]
//  cfg_mgmt_di          in   32  write data
//  cfg_mgmt_do          out  32  read data, valid with done, held until next read done
//  cfg_mgmt_rd_wr_done  out  1   one-cycle completion pulse
//  proto_err            out  1   one-cycle pulse: rd_en and wr_en both high at accept
//  rd_count             out  16  completed reads, wraps 16'hFFFF -> 0
//  wr_count             out  16  completed writes, wraps 16'hFFFF -> 0
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE; done=0, proto_err=0, do=0,
//   counters=0; dword0=ID_DW0, dword2=CLASS_DW2, all other dwords 0.
//  FSM: IDLE -> WAIT -> DONE -> RECOVER -> IDLE.
//  IDLE: cycle T with rd_en|wr_en high = accept; latch dwaddr, byte_en, di,
//   command (RD, WR, or ERR if both high); load latency counter; -> WAIT.
//   ERR: proto_err=1 in cycle T+1 only.
//  WAIT: counter decrements; done asserted in cycle T+RESP_LATENCY (RESP_LATENCY=1
//   -> done at T+1). Inputs other than the latched enable are ignored after accept.
//  Abort: latched enable (rd_en for RD, wr_en for WR, either for ERR) low in any
//   WAIT cycle -> IDLE next cycle; no done, no write, no counter change.
//  DONE (single cycle, done=1):
//   RD: do <= dword[addr] (0 if addr >= NUM_DW), same cycle as done; rd_count+1.
//   WR: bytes with byte_en=1 written; dwords 0,2 and addr >= NUM_DW unchanged
//    (done still pulses); wr_count+1. Write visible to any later accepted read.
//   ERR: do <= 0, no write, no counter change.
//  RECOVER: stay until rd_en=0 and wr_en=0 sampled, then IDLE next cycle; enables
//   still high in the done cycle (initiator registers its deassert) are not a new
//   request. Earliest next accept: done cycle + 2.
//  byte_en=4'h0 write: completes normally, dword unchanged, wr_count+1.
//  dwaddr bits above log2(NUM_DW) are compared, not truncated (no aliasing).
//  Reset mid-operation: done/proto_err drop immediately, pending write discarded.
// TESTING
//  Read dword0, LAT=4: rd_en=1 @T, addr=0 -> done=1 only @T+4, do=32'h7021_10EE, rd_count=1.
//  Write addr=5 di=32'hAABBCCDD be=4'b0101, then read 5 -> do=32'h00BB00DD, wr_count=1.
//  Write addr=2 di=32'hFFFFFFFF be=4'hF -> done pulses, read 2 returns 32'h0580_0000.
//  Read addr=10'h3FF -> do=0; write addr=64 then read 0..63 -> all unchanged.
//  rd_en&wr_en high @T -> proto_err @T+1, done @T+4, do=0, counters unchanged.
//  rd_en dropped @T+2 -> no done; rst_n low during WAIT -> done=0, counters 0.

Source files
------------

// File: rtl/pciecfg_mgmt_responder.sv
`default_nettype none
// ============================================================================
// Module   : pciecfg_mgmt_responder
// Brief    : Responder side of the PCIe cfg_mgmt interface. Services dword
//            read/write requests against a local configuration register file
//            with a fixed response latency.
// Revision : 1.0  initial release
// ============================================================================
module pciecfg_mgmt_responder #(
  parameter int          NUM_DW       = 64,
  parameter int          RESP_LATENCY = 4,
  parameter logic [31:0] ID_DW0       = 32'h7021_10EE,
  parameter logic [31:0] CLASS_DW2    = 32'h0580_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  cfg_mgmt_dwaddr,
  input  logic        cfg_mgmt_rd_en,
  input  logic        cfg_mgmt_wr_en,
  input  logic [3:0]  cfg_mgmt_byte_en,
  input  logic [31:0] cfg_mgmt_di,
  output logic [31:0] cfg_mgmt_do,
  output logic        cfg_mgmt_rd_wr_done,
  output logic        proto_err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int         c_aw      = (NUM_DW > 1) ? $clog2(NUM_DW) : 1;
  localparam logic [10:0] c_num_dw = 11'(NUM_DW);
  localparam logic [3:0] c_lat_m1  = 4'(RESP_LATENCY - 1);

  localparam logic [1:0] c_cmd_rd  = 2'd0;
  localparam logic [1:0] c_cmd_wr  = 2'd1;
  localparam logic [1:0] c_cmd_err = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DONE    = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [1:0]  r_cmd;
  logic [9:0]  r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_di;
  logic        r_done;
  logic        r_proto_err;
  logic [31:0] r_do;
  logic [15:0] r_rd_count;
  logic [15:0] r_wr_count;
  logic [31:0] r_mem [NUM_DW];

  logic [1:0]      w_cur_cmd;
  logic [9:0]      w_cur_addr;
  logic [3:0]      w_cur_be;
  logic [31:0]     w_cur_di;
  logic            w_in_range;
  logic [c_aw-1:0] w_idx;
  logic            w_wr_ok;
  logic [31:0]     w_rd_data;
  logic            w_en_held;
  logic            w_complete;

  // Current request fields: straight from the ports in IDLE (zero-wait
  // completion when the latency is one), otherwise the values latched at accept.
  always_comb begin
    w_cur_cmd  = r_cmd;
    w_cur_addr = r_addr;
    w_cur_be   = r_be;
    w_cur_di   = r_di;
    if (r_state == S_IDLE) begin
      w_cur_addr = cfg_mgmt_dwaddr;
      w_cur_be   = cfg_mgmt_byte_en;
      w_cur_di   = cfg_mgmt_di;
      if (cfg_mgmt_rd_en && cfg_mgmt_wr_en) w_cur_cmd = c_cmd_err;
      else if (cfg_mgmt_rd_en)              w_cur_cmd = c_cmd_rd;
      else                                  w_cur_cmd = c_cmd_wr;
    end
  end

  // Address decode: the full 10-bit address is range-checked so high
  // addresses never alias onto implemented dwords.
  always_comb begin
    w_in_range = ({1'b0, w_cur_addr} < c_num_dw);
    w_idx      = w_cur_addr[c_aw-1:0];
    w_wr_ok    = w_in_range && (w_cur_addr != 10'd0) && (w_cur_addr != 10'd2);
    w_rd_data  = 32'h0;
    if (w_in_range) begin
      if (w_cur_addr == 10'd0)      w_rd_data = ID_DW0;
      else if (w_cur_addr == 10'd2) w_rd_data = CLASS_DW2;
      else                          w_rd_data = r_mem[w_idx];
    end
  end

  // The enable that keeps a latched request alive; ERR needs both held.
  always_comb begin
    w_en_held = 1'b0;
    case (r_cmd)
      c_cmd_rd:  w_en_held = cfg_mgmt_rd_en;
      c_cmd_wr:  w_en_held = cfg_mgmt_wr_en;
      default:   w_en_held = cfg_mgmt_rd_en & cfg_mgmt_wr_en;
    endcase
  end

  // Completion fires on the edge that enters DONE.
  always_comb begin
    w_complete = 1'b0;
    if (r_state == S_IDLE)
      w_complete = (cfg_mgmt_rd_en || cfg_mgmt_wr_en) && (RESP_LATENCY == 1);
    else if (r_state == S_WAIT)
      w_complete = w_en_held && (r_cnt == 4'd1);
  end

  // Request FSM with registered done/proto_err, read data and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_cmd       <= c_cmd_rd;
      r_addr      <= 10'd0;
      r_be        <= 4'd0;
      r_di        <= 32'h0;
      r_done      <= 1'b0;
      r_proto_err <= 1'b0;
      r_do        <= 32'h0;
      r_rd_count  <= 16'd0;
      r_wr_count  <= 16'd0;
    end else begin
      r_done      <= 1'b0;
      r_proto_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_mgmt_rd_en || cfg_mgmt_wr_en) begin
            r_cmd       <= w_cur_cmd;
            r_addr      <= cfg_mgmt_dwaddr;
            r_be        <= cfg_mgmt_byte_en;
            r_di        <= cfg_mgmt_di;
            r_cnt       <= c_lat_m1;
            r_proto_err <= cfg_mgmt_rd_en & cfg_mgmt_wr_en;
            r_state     <= (RESP_LATENCY == 1) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!w_en_held)          r_state <= S_IDLE;
          else if (r_cnt == 4'd1)  r_state <= S_DONE;
          else                     r_cnt   <= r_cnt - 4'd1;
        end
        S_DONE: begin
          r_state <= S_RECOVER;
        end
        default: begin
          if (!cfg_mgmt_rd_en && !cfg_mgmt_wr_en) r_state <= S_IDLE;
        end
      endcase
      if (w_complete) begin
        r_done <= 1'b1;
        case (w_cur_cmd)
          c_cmd_rd: begin
            r_do       <= w_rd_data;
            r_rd_count <= r_rd_count + 16'd1;
          end
          c_cmd_wr: begin
            r_wr_count <= r_wr_count + 16'd1;
          end
          default: begin
            r_do <= 32'h0;
          end
        endcase
      end
    end
  end

  // Register file: byte-masked writes on completion; read-only and
  // unimplemented dwords are silently left alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DW; i++) r_mem[i] <= 32'h0;
    end else if (w_complete && (w_cur_cmd == c_cmd_wr) && w_wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (w_cur_be[b]) r_mem[w_idx][8*b +: 8] <= w_cur_di[8*b +: 8];
      end
    end
  end

  assign cfg_mgmt_do         = r_do;
  assign cfg_mgmt_rd_wr_done = r_done;
  assign proto_err           = r_proto_err;
  assign rd_count            = r_rd_count;
  assign wr_count            = r_wr_count;

endmodule
`default_nettype wire
